// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, FSM
// encodings, fetch-buffer geometry and the sequential PC increment.
package fetch_unit_pkg;

    localparam int WORDSIZE    = 32;
    localparam int FBUF_DEPTH  = 2;
    localparam int FBUF_PTR_W  = $clog2(FBUF_DEPTH);
    localparam int FBUF_CNT_W  = $clog2(FBUF_DEPTH + 1);

    typedef logic [WORDSIZE-1:0] word_t;

    localparam word_t PC_INC = word_t'(4);

    typedef enum logic {
        ST_FETCH = 1'b0,  // issuing requests
        ST_DRAIN = 1'b1   // discarding responses to requests made before a redirect
    } fetch_state_e;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer holding (instruction, pc) pairs.
// Supports push and pop in the same cycle; flush empties it at once.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_data,
    input  word_t push_pc,
    input  logic  pop,
    input  logic  flush,
    output word_t head_data,
    output word_t head_pc,
    output logic  full,
    output logic  empty
);

    word_t                 ent_data_q [FBUF_DEPTH];
    word_t                 ent_data_d [FBUF_DEPTH];
    word_t                 ent_pc_q   [FBUF_DEPTH];
    word_t                 ent_pc_d   [FBUF_DEPTH];
    logic [FBUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FBUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FBUF_CNT_W-1:0] count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count_q == FBUF_CNT_W'(FBUF_DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = ent_data_q[rd_ptr_q];
    assign head_pc   = ent_pc_q[rd_ptr_q];

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        ent_data_d = ent_data_q;
        ent_pc_d   = ent_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                ent_data_d[wr_ptr_q] = push_data;
                ent_pc_d[wr_ptr_q]   = push_pc;
                wr_ptr_d             = wr_ptr_q + FBUF_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + FBUF_PTR_W'(1);
            end
            count_d = count_q + FBUF_CNT_W'(do_push) - FBUF_CNT_W'(do_pop);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage register.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the zeroed count alone marks every entry invalid.
        ent_data_q <= ent_data_d;
        ent_pc_q   <= ent_pc_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory,
// buffers in-order responses for decode, and handles branch redirects by
// counting and discarding responses to requests made before the redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORDSIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect,
    input  logic [WORDSIZE-1:0] pc_addr,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORDSIZE-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [WORDSIZE-1:0] imem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [WORDSIZE-1:0] inst_data,
    output logic [WORDSIZE-1:0] inst_pc,
    output logic [WORDSIZE-1:0] incpc_out
);

    localparam int CNT_W = FBUF_CNT_W;

    fetch_state_e     state_q, state_d;
    word_t            pc_q, pc_d;
    word_t            resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;      // live requests awaiting a response
    logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;  // in-flight requests to be discarded
    logic [CNT_W:0]   in_flight;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W-1:0] buf_occ;
    logic             req_fire;
    logic             resp_live;
    logic             buf_full;
    logic             buf_empty;
    logic             buf_pop;
    word_t            head_data;
    word_t            head_pc;

    assign buf_occ   = buf_full ? CNT_W'(2) : (buf_empty ? CNT_W'(0) : CNT_W'(1));
    assign occupancy = {1'b0, out_cnt_q} + {1'b0, buf_occ};

    // Request side: gated by reset so nothing is offered while memory is held in reset.
    assign imem_req_valid = rst_n && (state_q == ST_FETCH) && !redirect
                            && (occupancy < (CNT_W+1)'(FBUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when nothing stale precedes it and no redirect squashes it.
    assign resp_live = imem_resp_valid && !redirect && (stale_cnt_q == '0);

    assign inst_valid = !buf_empty;
    assign inst_data  = inst_valid ? head_data : '0;
    assign inst_pc    = inst_valid ? head_pc : '0;
    assign incpc_out  = inst_pc + PC_INC;
    assign buf_pop    = inst_valid && inst_ready;

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_live),
        .push_data (imem_resp_data),
        .push_pc   (resp_pc_q),
        .pop       (buf_pop),
        .flush     (redirect),
        .head_data (head_data),
        .head_pc   (head_pc),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // PC and request-count bookkeeping; redirect takes priority over everything else.
    always_comb begin
        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        out_cnt_d   = out_cnt_q;
        stale_cnt_d = stale_cnt_q;
        in_flight   = {1'b0, stale_cnt_q} + {1'b0, out_cnt_q};
        if (redirect) begin
            pc_d      = align_word(pc_addr);
            resp_pc_d = align_word(pc_addr);
            out_cnt_d = '0;
            // Everything still in flight becomes stale; a same-cycle response consumes one.
            if (imem_resp_valid && (in_flight != '0)) begin
                in_flight = in_flight - (CNT_W+1)'(1);
            end
            stale_cnt_d = in_flight[CNT_W-1:0];
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_INC;
            end
            if (imem_resp_valid) begin
                if (stale_cnt_q != '0) begin
                    stale_cnt_d = stale_cnt_q - CNT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_q + PC_INC;
                end
            end
            out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(resp_live);
        end
    end

    // Next-state logic: drain while stale responses remain outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: if (redirect && (stale_cnt_d != '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (stale_cnt_d == '0) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            out_cnt_q   <= '0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            resp_pc_q   <= resp_pc_d;
            out_cnt_q   <= out_cnt_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference is a stream-level model:
// since the last reset/redirect, the n-th accepted request must be at
// base+4n and the n-th delivered instruction at base+4n; responses to requests
// accepted before a redirect are stale and must never reach decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] incpc_out;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect        (redirect),
        .pc_addr         (pc_addr),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .incpc_out       (incpc_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    // Memory model and stream model state.
    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] inc_log[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          total_pops = 0;
    logic [31:0] base_pc = RESET_PC;
    int          acc_n = 0;
    int          rsp_n = 0;
    int          pop_n = 0;
    logic        last_req_valid;
    logic        last_inst_valid;

    // Stimulus knobs: mode 0 = always 1, 1 = always 0, 2 = mostly 1 (random).
    logic        k_rst_n = 1'b0;
    logic        k_redirect = 1'b0;
    logic [31:0] k_pc_addr = '0;
    int          k_rdy_mode = 0;
    int          k_ird_mode = 0;
    int          k_lat_min = 0;
    int          k_lat_span = 0;
    logic        k_rsp_rand = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return $urandom_range(0, 3) != 0;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    function automatic int stale_count();
        int s = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) s++;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the
    // model, then advance the model at the rising edge.
    task automatic step();
        mreq_t       r;
        int          stale;
        logic        resp_v;
        logic        req_fire;
        logic        pop_ev;
        logic [31:0] addr_s;
        logic [31:0] exp_pc;
        rst_n          = k_rst_n;
        redirect       = k_redirect;
        pc_addr        = k_pc_addr;
        imem_req_ready = pick(k_rdy_mode);
        inst_ready     = pick(k_ird_mode);
        resp_v = (mq.size() > 0) && (mq[0].due <= cyc)
                 && (!k_rsp_rand || ($urandom_range(0, 2) != 0));
        imem_resp_valid = resp_v;
        imem_resp_data  = resp_v ? mem_word(mq[0].addr) : $urandom();
        #1;
        stale = stale_count();
        check("req_valid", 32'(imem_req_valid),
              32'(rst_n && !redirect && (stale == 0) && ((acc_n - pop_n) < 2)));
        if (imem_req_valid) check("req_addr", imem_req_addr, base_pc + 32'(4 * acc_n));
        check("inst_valid", 32'(inst_valid), 32'((rsp_n - pop_n) > 0));
        if (inst_valid) begin
            exp_pc = base_pc + 32'(4 * pop_n);
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, mem_word(exp_pc));
            check("incpc_out", incpc_out, exp_pc + 32'd4);
        end
        req_fire        = imem_req_valid && imem_req_ready;
        pop_ev          = inst_valid && inst_ready && !redirect && rst_n;
        addr_s          = imem_req_addr;
        last_req_valid  = imem_req_valid;
        last_inst_valid = inst_valid;
        if (req_fire) req_log.push_back(addr_s);
        if (pop_ev) begin
            pop_log.push_back(inst_pc);
            inc_log.push_back(incpc_out);
            total_pops++;
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            epoch++;
            base_pc = RESET_PC;
            acc_n = 0; rsp_n = 0; pop_n = 0;
        end else begin
            if (resp_v) begin
                r = mq.pop_front();
                if (!redirect && (r.epoch == epoch)) rsp_n++;
            end
            if (redirect) begin
                epoch++;
                base_pc = pc_addr & 32'hFFFF_FFFC;
                acc_n = 0; rsp_n = 0; pop_n = 0;
            end else begin
                if (req_fire) begin
                    mq.push_back('{addr: addr_s, epoch: epoch,
                                   due: cyc + 1 + k_lat_min + int'($urandom_range(0, k_lat_span))});
                    acc_n++;
                end
                if (pop_ev) pop_n++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        k_rst_n = 1'b0; k_redirect = 1'b0;
        steps(2);
        k_rst_n = 1'b1;
        k_rdy_mode = 0; k_ird_mode = 0; k_lat_min = 0; k_lat_span = 0; k_rsp_rand = 1'b0;
        req_log.delete(); pop_log.delete(); inc_log.delete();
    endtask

    task automatic clear_logs();
        req_log.delete(); pop_log.delete(); inc_log.delete();
    endtask

    // Two requests in flight with 3-cycle latency, then a redirect to 0x100.
    task automatic redirect_with_two_outstanding();
        do_reset();
        k_ird_mode = 1; k_lat_min = 3;
        steps(2);
        clear_logs();
        k_redirect = 1'b1; k_pc_addr = 32'h0000_0100;
        step();
        k_redirect = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Basic streaming from reset: requests 0,4,8; first instruction at 0.
        do_reset();
        check("reset_req_valid", 32'(last_req_valid), 32'd0);
        check("reset_inst_valid", 32'(last_inst_valid), 32'd0);
        steps(8);
        check("seq_req0", qat(req_log, 0), 32'h0);
        check("seq_req1", qat(req_log, 1), 32'h4);
        check("seq_req2", qat(req_log, 2), 32'h8);
        check("seq_pop0_pc", qat(pop_log, 0), 32'h0);
        check("seq_pop0_inc", qat(inc_log, 0), 32'h4);

        // Decode stalled: exactly two requests, then fetch pauses.
        do_reset();
        k_ird_mode = 1;
        steps(10);
        check("stall_req_count", 32'(req_log.size()), 32'd2);
        check("stall_req_valid", 32'(last_req_valid), 32'd0);
        clear_logs();
        k_ird_mode = 0;
        steps(6);
        check("stall_pop0", qat(pop_log, 0), 32'h0);
        check("stall_pop1", qat(pop_log, 1), 32'h4);
        check("stall_resume", qat(req_log, 0), 32'h8);

        // Redirect with two outstanding: both dropped, stream restarts at 0x100.
        redirect_with_two_outstanding();
        check("drain_no_req", 32'(last_req_valid), 32'd0);
        k_ird_mode = 0;
        steps(15);
        check("drain_first_req", qat(req_log, 0), 32'h100);
        check("drain_first_pc", qat(pop_log, 0), 32'h100);
        check("drain_first_inc", qat(inc_log, 0), 32'h104);

        // Redirect in the same cycle as a response: that response is dropped.
        do_reset();
        step();
        clear_logs();
        k_redirect = 1'b1; k_pc_addr = 32'h0000_0200;
        step();
        k_redirect = 1'b0;
        steps(8);
        check("samecyc_req", qat(req_log, 0), 32'h200);
        check("samecyc_pop", qat(pop_log, 0), 32'h200);

        // Memory not ready for 3 cycles: address held, then unaligned redirect target.
        do_reset();
        k_rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_addr", imem_req_addr, 32'h0);
        end
        check("hold_no_fire", 32'(req_log.size()), 32'd0);
        k_redirect = 1'b1; k_pc_addr = 32'h0000_0103;
        step();
        k_redirect = 1'b0; k_rdy_mode = 0;
        steps(4);
        check("unaligned_req", qat(req_log, 0), 32'h100);

        // Reset while draining: outputs quiet, restart at RESET_PC.
        redirect_with_two_outstanding();
        step();
        k_rst_n = 1'b0;
        steps(2);
        check("rst_drain_req_valid", 32'(last_req_valid), 32'd0);
        check("rst_drain_inst_valid", 32'(last_inst_valid), 32'd0);
        k_rst_n = 1'b1; k_ird_mode = 0; k_lat_min = 0;
        clear_logs();
        steps(5);
        check("rst_drain_restart", qat(req_log, 0), RESET_PC);

        // Randomized traffic checked cycle by cycle against the stream model.
        total_pops = 0;
        for (int i = 0; i < 4000; i++) begin
            k_rdy_mode = 2; k_ird_mode = 2; k_rsp_rand = 1'b1;
            k_lat_min = 0; k_lat_span = 3;
            k_rst_n    = ($urandom_range(0, 399) != 0);
            k_redirect = ($urandom_range(0, 29) == 0);
            k_pc_addr  = $urandom();
            step();
        end
        check("random_progress", 32'(total_pops > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
